// File: rtl/ntt_commutator.sv
// ntt_commutator: delay-commutator pairing coefficients DEPTH beats apart between butterfly stages
module ntt_commutator #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);
  localparam int LG = $clog2(DEPTH);
  localparam logic [LG:0] FULL = (LG+1)'(DEPTH);
  localparam logic [LG:0] ONE = (LG+1)'(1);
  typedef enum logic {FILL, RUN} state_t;
  state_t state;
  logic [LG:0] t, fill, tb, fb;
  logic sel, go;
  logic [WIDTH-1:0] bd, ud, u, v;
  // a clear restarts the frame in the same cycle, so a concurrent beat becomes beat 0
  always_comb begin
    tb = clr ? '0 : t;
    fb = clr ? '0 : fill;
    sel = tb[LG];
    u = sel ? bd : in_a;
    v = sel ? in_a : bd;
    go = in_valid && !clr && (state == RUN || fill == FULL);
  end
  generate
    if (DEPTH == 1) begin : g_reg
      logic [WIDTH-1:0] rb, ru;
      // single-beat delay lines are plain registers
      always_ff @(posedge clk)
        if (in_valid) begin
          rb <= in_b;
          ru <= u;
        end
      assign bd = rb;
      assign ud = ru;
    end else begin : g_mem
      logic [WIDTH-1:0] mb [DEPTH];
      logic [WIDTH-1:0] mu [DEPTH];
      logic [LG-1:0] addr;
      assign addr = tb[LG-1:0];
      // read-before-write delay memories; the read returns the sample DEPTH beats old
      always_ff @(posedge clk)
        if (in_valid) begin
          mb[addr] <= in_b;
          mu[addr] <= u;
        end
      assign bd = mb[addr];
      assign ud = mu[addr];
    end
  endgenerate
  // beat/fill counters, fill-run state and registered output pair
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      t <= '0;
      fill <= '0;
      out_valid <= 1'b0;
      out_a <= '0;
      out_b <= '0;
    end else begin
      t <= in_valid ? tb + ONE : tb;
      fill <= (in_valid && fb != FULL) ? fb + ONE : fb;
      state <= clr ? FILL : (go ? RUN : state);
      out_valid <= go;
      if (go) begin
        out_a <= ud;
        out_b <= v;
      end
    end
endmodule

// File: tb/tb_ntt_commutator.sv
// tb_ntt_commutator: directed checks of the commutator at DEPTH 1, 4 and 8
module tb_ntt_commutator;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0;
  logic [11:0] in_a = '0, in_b = '0;
  logic v1, v4, v8;
  logic [11:0] a1, b1, a4, b4, a8, b8;
  int vecs = 0, errs = 0;
  int qa[$], qb[$];
  int ta[12] = '{0, 1, 2, 3, 100, 101, 102, 103, 8, 9, 10, 11};
  int tbv[12] = '{4, 5, 6, 7, 104, 105, 106, 107, 12, 13, 14, 15};
  int da[5] = '{0, 50, 2, 52, 4};
  int db[5] = '{1, 51, 3, 53, 5};

  always #5 clk = ~clk;

  ntt_commutator #(.WIDTH(12), .DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .out_valid(v1), .out_a(a1), .out_b(b1));
  ntt_commutator #(.WIDTH(12), .DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .out_valid(v4), .out_a(a4), .out_b(b4));
  ntt_commutator #(.WIDTH(12), .DEPTH(8)) u_d8 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .out_valid(v8), .out_a(a8), .out_b(b8));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic beat(input bit v, input bit c, input int a, input int b);
    @(negedge clk);
    in_valid = v;
    clr = c;
    in_a = 12'(a);
    in_b = 12'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input int d, output logic ov, output logic [31:0] oa, output logic [31:0] ob);
    ov = d == 1 ? v1 : d == 4 ? v4 : v8;
    oa = 32'(d == 1 ? a1 : d == 4 ? a4 : a8);
    ob = 32'(d == 1 ? b1 : d == 4 ? b4 : b8);
  endtask

  task automatic run(input int d, input int t0, input int n, input int ba, input int bb, input bit gaps);
    logic ov;
    logic [31:0] oa, ob, ea, eb;
    bit seen;
    int p, k, j;
    seen = 0;
    ea = 0;
    eb = 0;
    qa.delete();
    qb.delete();
    for (int t = t0; t < n; t++) begin
      for (int g = 0; g < 3 && gaps && $urandom_range(0, 9) < 4; g++) begin
        beat(0, 0, 0, 0);
        obs(d, ov, oa, ob);
        chk("gap_valid", 32'(ov), 0);
        if (seen) begin
          chk("hold_a", oa, ea);
          chk("hold_b", ob, eb);
        end
      end
      beat(1, 0, ba + t, bb + t);
      obs(d, ov, oa, ob);
      chk("valid", 32'(ov), 32'(t >= d));
      if (t >= d) begin
        p = t - d;
        k = p / (2 * d);
        j = p % (2 * d);
        ea = 32'(j < d ? ba + 2 * d * k + j : bb + 2 * d * k + j - d);
        eb = ea + 32'(d);
        seen = 1;
        chk("pair_a", oa, ea);
        chk("pair_b", ob, eb);
        qa.push_back(int'(oa));
        qb.push_back(int'(ob));
      end
    end
  endtask

  task automatic tab4(input string tag);
    chk({tag, "_count"}, 32'(qa.size()), 12);
    for (int i = 0; i < 12; i++) begin
      chk({tag, "_a"}, 32'(i < qa.size() ? qa[i] : -1), 32'(ta[i]));
      chk({tag, "_b"}, 32'(i < qb.size() ? qb[i] : -1), 32'(tbv[i]));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v4", 32'(v4), 0);
    chk("rst_a4", 32'(a4), 0);
    chk("rst_b4", 32'(b4), 0);
    chk("rst_v1", 32'(v1), 0);
    chk("rst_v8", 32'(v8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(4, 0, 16, 0, 100, 0);
    tab4("cont");
    beat(0, 1, 0, 0);
    chk("clr_idle_valid", 32'(v4), 0);
    run(4, 0, 16, 0, 100, 1);
    tab4("gaps");
    beat(0, 1, 0, 0);
    run(4, 0, 6, 0, 100, 0);
    beat(1, 1, 200, 300);
    chk("clr_beat_valid", 32'(v4), 0);
    run(4, 1, 12, 200, 300, 0);
    chk("new_first_a", 32'(qa.size() > 0 ? qa[0] : -1), 200);
    chk("new_first_b", 32'(qb.size() > 0 ? qb[0] : -1), 204);
    chk("new_pre_rst_v", 32'(v4), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_v", 32'(v4), 0);
    chk("async_rst_a", 32'(a4), 0);
    chk("async_rst_b", 32'(b4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    run(4, 0, 16, 0, 100, 0);
    tab4("after_rst");
    beat(0, 1, 0, 0);
    run(1, 0, 6, 0, 50, 0);
    chk("d1_count", 32'(qa.size()), 5);
    for (int i = 0; i < 5; i++) begin
      chk("d1_a", 32'(i < qa.size() ? qa[i] : -1), 32'(da[i]));
      chk("d1_b", 32'(i < qb.size() ? qb[i] : -1), 32'(db[i]));
    end
    beat(0, 1, 0, 0);
    run(8, 0, 64, 0, 500, 0);
    chk("d8_count", 32'(qa.size()), 56);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
